// File: rtl/pipe_exc_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_exc_ctrl_if
//  Purpose  : Bundles the pipeline-facing signals of the exception/interrupt
//             sequencer. The pipeline uses the "master" modport: it drives the
//             event inputs and receives the stall/flush/PC/CP0 controls. The
//             sequencer uses the "slave" modport.
//  Signals  : irq[N_IRQ], ie, ov_ex, ex_pc[32], id_pc[32], eret_id, load_use
//             -> stall_if, stall_id, flush_id, flush_ex, flush_mem, pc_sel[2],
//                epc_we, epc_o[32], cause_we, exc_code[5], ie_clr, ie_set,
//                busy
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_exc_ctrl_if #(
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] irq;
  logic             ie;
  logic             ov_ex;
  logic [31:0]      ex_pc;
  logic [31:0]      id_pc;
  logic             eret_id;
  logic             load_use;

  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic [1:0]       pc_sel;
  logic             epc_we;
  logic [31:0]      epc_o;
  logic             cause_we;
  logic [4:0]       exc_code;
  logic             ie_clr;
  logic             ie_set;
  logic             busy;

  modport master (
    output irq, ie, ov_ex, ex_pc, id_pc, eret_id, load_use,
    input  stall_if, stall_id, flush_id, flush_ex, flush_mem, pc_sel,
           epc_we, epc_o, cause_we, exc_code, ie_clr, ie_set, busy
  );

  modport slave (
    input  irq, ie, ov_ex, ex_pc, id_pc, eret_id, load_use,
    output stall_if, stall_id, flush_id, flush_ex, flush_mem, pc_sel,
           epc_we, epc_o, cause_we, exc_code, ie_clr, ie_set, busy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_exc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_exc_ctrl
//  Purpose  : Exception/interrupt sequencer for the 5-stage CPU. Arbitrates
//             EX overflow, external interrupts, eret and load-use hazards,
//             drives stall/flush/PC-select controls and CP0 EPC/Cause writes,
//             and drains the pipe for DRAIN_CYC cycles before vectoring.
//  Ports    : clk, rst (async, active-high)
//             bus : pipe_exc_ctrl_if.slave (event inputs in, controls out)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_exc_ctrl #(
  parameter int         N_IRQ     = 4,
  parameter int         DRAIN_CYC = 2,
  parameter logic [4:0] OV_CODE   = 5'd12
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_exc_ctrl_if.slave     bus
);

  localparam int         c_IDX_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [2:0] c_CNT_INIT = 3'(DRAIN_CYC - 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_VEC   = 2'd2;

  logic [1:0]         r_state, w_state_nx;
  logic [N_IRQ-1:0]   r_pend,  w_pend_nx, w_pend_clr;
  logic [2:0]         r_cnt,   w_cnt_nx;
  logic [c_IDX_W-1:0] r_idx,   w_idx_nx, w_sel;
  logic               r_is_irq, w_is_irq_nx;
  logic               w_irq_go;

  // Lowest set pending index wins (line 0 highest priority).
  always_comb begin
    w_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel = c_IDX_W'(i);
    end
  end

  assign w_irq_go = (|r_pend) && bus.ie && !bus.load_use;

  // State register, pending latch, drain counter and taken-event record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pend   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_is_irq <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pend   <= w_pend_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_is_irq <= w_is_irq_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_is_irq_nx = r_is_irq;
    w_pend_clr  = '0;
    case (r_state)
      S_RUN: begin
        if (bus.ov_ex) begin
          w_state_nx  = S_DRAIN;
          w_cnt_nx    = c_CNT_INIT;
          w_is_irq_nx = 1'b0;
        end else if (bus.eret_id) begin
          w_state_nx = S_RUN;
        end else if (w_irq_go) begin
          w_state_nx  = S_DRAIN;
          w_cnt_nx    = c_CNT_INIT;
          w_idx_nx    = w_sel;
          w_is_irq_nx = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 3'd0) w_state_nx = S_VEC;
        else               w_cnt_nx   = r_cnt - 3'd1;
      end
      S_VEC: begin
        // Overflow entries have no pending bit to retire.
        for (int i = 0; i < N_IRQ; i++) begin
          if (r_is_irq && (r_idx == c_IDX_W'(i))) w_pend_clr[i] = 1'b1;
        end
        w_state_nx = S_RUN;
      end
      default: w_state_nx = S_RUN;
    endcase
    // A new request in the same cycle as its clear keeps the bit set.
    w_pend_nx = (r_pend & ~w_pend_clr) | bus.irq;
  end

  // Mealy output logic.
  always_comb begin
    bus.stall_if  = 1'b0;
    bus.stall_id  = 1'b0;
    bus.flush_id  = 1'b0;
    bus.flush_ex  = 1'b0;
    bus.flush_mem = 1'b0;
    bus.pc_sel    = 2'b00;
    bus.epc_we    = 1'b0;
    bus.epc_o     = 32'd0;
    bus.cause_we  = 1'b0;
    bus.exc_code  = 5'd0;
    bus.ie_clr    = 1'b0;
    bus.ie_set    = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.ov_ex) begin
          // The faulting instruction is in EX: kill it and everything younger.
          bus.flush_id  = 1'b1;
          bus.flush_ex  = 1'b1;
          bus.flush_mem = 1'b1;
          bus.stall_if  = 1'b1;
          bus.epc_we    = 1'b1;
          bus.epc_o     = bus.ex_pc;
          bus.cause_we  = 1'b1;
          bus.exc_code  = OV_CODE;
        end else if (bus.eret_id) begin
          bus.pc_sel   = 2'b10;
          bus.flush_id = 1'b1;
          bus.ie_set   = 1'b1;
        end else if (w_irq_go) begin
          // Interrupt restarts at the instruction in ID; older ones complete.
          bus.flush_id = 1'b1;
          bus.stall_if = 1'b1;
          bus.epc_we   = 1'b1;
          bus.epc_o    = bus.id_pc;
          bus.cause_we = 1'b1;
          bus.exc_code = 5'(w_sel);
        end else if (bus.load_use) begin
          bus.stall_if = 1'b1;
          bus.stall_id = 1'b1;
          bus.flush_ex = 1'b1;
        end
      end
      S_DRAIN: begin
        bus.stall_if = 1'b1;
        bus.flush_id = 1'b1;
        bus.busy     = 1'b1;
      end
      S_VEC: begin
        bus.pc_sel = 2'b01;
        bus.ie_clr = 1'b1;
        bus.busy   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_exc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_exc_ctrl
//  Purpose  : Directed self-checking bench for pipe_exc_ctrl. Control outputs
//             are packed as {stall_if, stall_id, flush_id, flush_ex, flush_mem,
//             pc_sel[1:0], epc_we, cause_we, ie_clr, ie_set, busy}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_exc_ctrl;

  localparam logic [11:0] c_IDLE  = 12'h000;
  localparam logic [11:0] c_OV    = 12'hB98;
  localparam logic [11:0] c_IRQ   = 12'hA18;
  localparam logic [11:0] c_DRAIN = 12'hA01;
  localparam logic [11:0] c_VEC   = 12'h025;
  localparam logic [11:0] c_ERET  = 12'h242;
  localparam logic [11:0] c_LU    = 12'hD00;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  pipe_exc_ctrl_if #(.N_IRQ(4)) bus ();

  pipe_exc_ctrl #(.N_IRQ(4), .DRAIN_CYC(2), .OV_CODE(5'd12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [11:0] ctl,
                         input logic [31:0] epc, input logic [4:0] code);
    chk({tag, ".ctl"}, 32'({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex,
                            bus.flush_mem, bus.pc_sel, bus.epc_we, bus.cause_we,
                            bus.ie_clr, bus.ie_set, bus.busy}), 32'(ctl));
    chk({tag, ".epc"}, bus.epc_o, epc);
    chk({tag, ".code"}, 32'(bus.exc_code), 32'(code));
  endtask

  // Check Mealy outputs mid-cycle, then advance past the next active edge.
  task automatic step(input string tag, input logic [11:0] ctl,
                      input logic [31:0] epc, input logic [4:0] code);
    @(negedge clk);
    chk_out(tag, ctl, epc, code);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.irq      = 4'b0000;
    bus.ie       = 1'b0;
    bus.ov_ex    = 1'b0;
    bus.ex_pc    = 32'h0;
    bus.id_pc    = 32'h0;
    bus.eret_id  = 1'b0;
    bus.load_use = 1'b0;
    step("reset", c_IDLE, 32'h0, 5'd0);
    rst = 1'b0;

    // Overflow entry and drain.
    bus.ie = 1'b1; bus.ov_ex = 1'b1; bus.ex_pc = 32'h40;
    step("ov_accept", c_OV, 32'h40, 5'd12);
    bus.ov_ex = 1'b0;
    step("ov_drain1", c_DRAIN, 32'h0, 5'd0);
    step("ov_drain2", c_DRAIN, 32'h0, 5'd0);
    step("ov_vec", c_VEC, 32'h0, 5'd0);
    step("ov_run", c_IDLE, 32'h0, 5'd0);

    // Priority: lines 1 and 2 together, line 1 first.
    bus.irq = 4'b0110; bus.id_pc = 32'h100;
    step("pri_latch", c_IDLE, 32'h0, 5'd0);
    bus.irq = 4'b0000;
    step("pri_irq1", c_IRQ, 32'h100, 5'd1);
    step("pri_drain1", c_DRAIN, 32'h0, 5'd0);
    step("pri_drain2", c_DRAIN, 32'h0, 5'd0);
    step("pri_vec1", c_VEC, 32'h0, 5'd0);
    bus.ie = 1'b0;
    step("pri_masked", c_IDLE, 32'h0, 5'd0);
    bus.eret_id = 1'b1;
    step("pri_eret", c_ERET, 32'h0, 5'd0);
    bus.eret_id = 1'b0; bus.ie = 1'b1; bus.id_pc = 32'h104;
    step("pri_irq2", c_IRQ, 32'h104, 5'd2);
    step("pri_drain3", c_DRAIN, 32'h0, 5'd0);
    step("pri_drain4", c_DRAIN, 32'h0, 5'd0);
    bus.irq = 4'b0100;  // re-request during its own clear
    step("pri_vec2", c_VEC, 32'h0, 5'd0);
    bus.irq = 4'b0000; bus.id_pc = 32'h108;
    step("setwins_irq2", c_IRQ, 32'h108, 5'd2);
    step("setwins_drain1", c_DRAIN, 32'h0, 5'd0);
    step("setwins_drain2", c_DRAIN, 32'h0, 5'd0);
    step("setwins_vec", c_VEC, 32'h0, 5'd0);
    step("pend_empty", c_IDLE, 32'h0, 5'd0);

    // Overflow beats a pending line 0, which survives the overflow VEC.
    bus.ie = 1'b0; bus.irq = 4'b0001;
    step("ovirq_latch", c_IDLE, 32'h0, 5'd0);
    bus.irq = 4'b0000; bus.ov_ex = 1'b1; bus.ie = 1'b1; bus.ex_pc = 32'h200;
    step("ovirq_ov", c_OV, 32'h200, 5'd12);
    bus.ov_ex = 1'b0;
    step("ovirq_drain1", c_DRAIN, 32'h0, 5'd0);
    step("ovirq_drain2", c_DRAIN, 32'h0, 5'd0);
    step("ovirq_vec", c_VEC, 32'h0, 5'd0);
    bus.id_pc = 32'h10C;
    step("ovirq_irq0", c_IRQ, 32'h10C, 5'd0);
    step("ovirq_drain3", c_DRAIN, 32'h0, 5'd0);
    step("ovirq_drain4", c_DRAIN, 32'h0, 5'd0);
    step("ovirq_vec2", c_VEC, 32'h0, 5'd0);

    // Masking and load-use hazard hold off a pending line 3.
    bus.ie = 1'b0; bus.irq = 4'b1000;
    step("mask_latch", c_IDLE, 32'h0, 5'd0);
    bus.irq = 4'b0000;
    step("mask_idle", c_IDLE, 32'h0, 5'd0);
    bus.ie = 1'b1; bus.load_use = 1'b1;
    step("lu_stall1", c_LU, 32'h0, 5'd0);
    step("lu_stall2", c_LU, 32'h0, 5'd0);
    bus.load_use = 1'b0; bus.id_pc = 32'h110;
    step("lu_irq3", c_IRQ, 32'h110, 5'd3);
    step("lu_drain1", c_DRAIN, 32'h0, 5'd0);
    step("lu_drain2", c_DRAIN, 32'h0, 5'd0);
    step("lu_vec", c_VEC, 32'h0, 5'd0);

    // eret blocks a pending line 3 for one cycle.
    bus.ie = 1'b0; bus.irq = 4'b1000;
    step("eret_latch", c_IDLE, 32'h0, 5'd0);
    bus.irq = 4'b0000; bus.eret_id = 1'b1;
    step("eret_pc", c_ERET, 32'h0, 5'd0);
    bus.eret_id = 1'b0; bus.ie = 1'b1; bus.id_pc = 32'h114;
    step("eret_irq3", c_IRQ, 32'h114, 5'd3);
    bus.irq = 4'b0001;  // latches into pend during DRAIN
    step("eret_drain1", c_DRAIN, 32'h0, 5'd0);
    bus.irq = 4'b0000;

    // Asynchronous reset in the middle of DRAIN.
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_async", c_IDLE, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_after1", c_IDLE, 32'h0, 5'd0);
    step("rst_after2", c_IDLE, 32'h0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
